time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter P_24H, default 1, selecting 24-hour mode (1) or 12-hour mode with AM/PM flag (0).
REQ-002 SHALL have port i_clk  input  1  system clock, 12 MHz; sole clock.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_tick_1hz  input  1  one-cycle pulse once per second from the upstream tick generator.
REQ-005 SHALL have port i_btn_mode  input  1  debounced one-cycle pulse that advances the set-mode state.
REQ-006 SHALL have port i_btn_inc  input  1  debounced one-cycle pulse that increments the field being set.
REQ-007 SHALL have port o_hours_bcd  output  8  hours as two BCD digits, tens in [7:4], units in [3:0].
REQ-008 SHALL have port o_minutes_bcd  output  8  minutes as two BCD digits, 00-59.
REQ-009 SHALL have port o_seconds_bcd  output  8  seconds as two BCD digits, 00-59.
REQ-010 SHALL have port o_pm  output  1  PM flag; constant 0 when P_24H=1.
REQ-011 SHALL have port o_set_hours  output  1  high while in state SET_HOURS.
REQ-012 SHALL have port o_set_minutes  output  1  high while in state SET_MINUTES.
REQ-013 SHALL have port o_day_carry  output  1  one-cycle pulse on midnight rollover.

Function
REQ-014 SHALL register every output directly, with no combinational input-to-output paths.
REQ-015 SHALL implement states RUN, SET_HOURS and SET_MINUTES.
REQ-016 SHALL transition on i_btn_mode: RUN->SET_HOURS->SET_MINUTES->RUN; all other states are held.
REQ-017 SHALL, on the SET_MINUTES->RUN transition, clear seconds to 00 in the same edge.
REQ-018 SHALL, in RUN, advance time by 1 s on i_tick_1hz, with outputs showing the new value the cycle after the tick edge.
REQ-019 SHALL keep each BCD digit valid: units 9->0 with carry to tens; seconds and minutes wrap 59->00 with carry to the next field.
REQ-020 SHALL, when P_24H=1, count hours 00-23, wrapping 23->00 on carry.
REQ-021 SHALL, when P_24H=0, count hours in the sequence 12,01,...,11,12.
REQ-022 SHALL, when P_24H=0, toggle o_pm on the 11->12 hour transition.
REQ-023 SHALL pulse o_day_carry for exactly one cycle when a RUN tick produces 00:00:00 (24 h) or 12:00:00 with o_pm=0 (12 h).
REQ-024 SHALL ignore i_tick_1hz in SET_HOURS and SET_MINUTES, with time frozen and no seconds accumulated.
REQ-025 SHALL ignore i_btn_inc in RUN.
REQ-026 SHALL, in SET_HOURS, increment hours by one per i_btn_inc using the REQ-020/021/022 wrap rules, never asserting o_day_carry.
REQ-027 SHALL, in SET_MINUTES, increment minutes by one per i_btn_inc, wrapping 59->00 with no carry into hours.
REQ-028 SHALL give i_btn_mode priority over i_btn_inc when both arrive in the same cycle: the state advances and the increment is dropped.
REQ-029 SHALL, in RUN, apply a tick coincident with i_btn_mode (time advances) and enter SET_HOURS in the same edge.
REQ-030 SHALL assert o_set_hours and o_set_minutes from the state register, one-hot, and both low in RUN.

Reset
REQ-031 SHALL, on i_reset, enter RUN; time 00:00:00 when P_24H=1, 12:00:00 when P_24H=0; o_pm=0, o_day_carry=0, o_set_hours=0, o_set_minutes=0.
REQ-032 SHALL, when i_reset is asserted mid-operation (any state, coincident with any input), apply reset values on that edge and discard all other inputs.

Verification
REQ-033 SHALL be verified: P_24H=1, preload 23:59:59, one tick -> 00:00:00 next cycle, o_day_carry high exactly 1 cycle.
REQ-034 SHALL be verified: P_24H=0, 11:59:59 o_pm=0, tick -> 12:00:00 o_pm=1, no carry; 11:59:59 o_pm=1, tick -> 12:00:00 o_pm=0, carry pulse.
REQ-035 SHALL be verified: seconds=37, mode, 3x inc (hours 00->03), mode, 61x inc (minutes 00->01 via 59->00, hours stay 03), mode -> RUN at 03:01:00; ticks during set are ignored.
REQ-036 SHALL be verified: mode and inc in the same cycle in SET_HOURS -> state SET_MINUTES, hours unchanged.
REQ-037 SHALL be verified: 09:59:59 with tick and mode coincident in RUN -> 10:00:00 and o_set_hours=1.
REQ-038 SHALL be verified: reset asserted in SET_MINUTES with inc pending -> next cycle RUN, time at reset value, flags 0.

Source files
------------

// File: rtl/time_keeper_if.sv
// time_keeper_if: button/tick inputs and BCD time outputs of the clock core
interface time_keeper_if;
  logic       i_tick_1hz;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic [7:0] o_hours_bcd;
  logic [7:0] o_minutes_bcd;
  logic [7:0] o_seconds_bcd;
  logic       o_pm;
  logic       o_set_hours;
  logic       o_set_minutes;
  logic       o_day_carry;
  modport master (
    output i_tick_1hz, i_btn_mode, i_btn_inc,
    input  o_hours_bcd, o_minutes_bcd, o_seconds_bcd, o_pm, o_set_hours, o_set_minutes, o_day_carry
  );
  modport slave (
    input  i_tick_1hz, i_btn_mode, i_btn_inc,
    output o_hours_bcd, o_minutes_bcd, o_seconds_bcd, o_pm, o_set_hours, o_set_minutes, o_day_carry
  );
endinterface

// File: rtl/time_keeper.sv
// time_keeper: BCD time-of-day counter with button-driven hour/minute setting
module time_keeper #(
  parameter bit P_24H = 1'b1
) (
  input logic         i_clk,
  input logic         i_reset,
  time_keeper_if.slave tk
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOURS = 2'b01, SET_MINUTES = 2'b10} state_t;
  localparam logic [7:0] HR_RST = P_24H ? 8'h00 : 8'h12;
  state_t     st_q, st_d;
  logic [7:0] hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
  logic       pm_q, pm_d, cy_q, cy_d;
  logic       sc_wrap, mn_wrap, hr_pm_edge;
  function automatic logic [7:0] inc_bcd(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] inc60(input logic [7:0] v);
    return v == 8'h59 ? 8'h00 : inc_bcd(v);
  endfunction
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    return P_24H ? (v == 8'h23 ? 8'h00 : inc_bcd(v)) : (v == 8'h12 ? 8'h01 : inc_bcd(v));
  endfunction
  always_ff @(posedge i_clk)
    st_q <= i_reset ? RUN : st_d;
  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:         st_d = tk.i_btn_mode ? SET_HOURS : RUN;
      SET_HOURS:   st_d = tk.i_btn_mode ? SET_MINUTES : SET_HOURS;
      SET_MINUTES: st_d = tk.i_btn_mode ? RUN : SET_MINUTES;
      default:     st_d = RUN;
    endcase
  end
  always_comb begin
    tk.o_set_hours   = st_q[0];
    tk.o_set_minutes = st_q[1];
  end
  assign sc_wrap    = sc_q == 8'h59;
  assign mn_wrap    = mn_q == 8'h59;
  assign hr_pm_edge = !P_24H && hr_q == 8'h11;
  // mode always wins over inc; ticks only count while running
  always_comb begin
    hr_d = hr_q;
    mn_d = mn_q;
    sc_d = sc_q;
    pm_d = pm_q;
    cy_d = 1'b0;
    case (st_q)
      RUN: if (tk.i_tick_1hz) begin
        sc_d = inc60(sc_q);
        mn_d = sc_wrap ? inc60(mn_q) : mn_q;
        hr_d = sc_wrap && mn_wrap ? inc_hr(hr_q) : hr_q;
        pm_d = sc_wrap && mn_wrap && hr_pm_edge ? ~pm_q : pm_q;
        cy_d = sc_wrap && mn_wrap && (P_24H ? hr_q == 8'h23 : hr_pm_edge && pm_q);
      end
      SET_HOURS: if (!tk.i_btn_mode && tk.i_btn_inc) begin
        hr_d = inc_hr(hr_q);
        pm_d = hr_pm_edge ? ~pm_q : pm_q;
      end
      SET_MINUTES: begin
        sc_d = tk.i_btn_mode ? 8'h00 : sc_q;
        mn_d = !tk.i_btn_mode && tk.i_btn_inc ? inc60(mn_q) : mn_q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      hr_q <= HR_RST;
      mn_q <= 8'h00;
      sc_q <= 8'h00;
      pm_q <= 1'b0;
      cy_q <= 1'b0;
    end else begin
      hr_q <= hr_d;
      mn_q <= mn_d;
      sc_q <= sc_d;
      pm_q <= pm_d;
      cy_q <= cy_d;
    end
  assign tk.o_hours_bcd   = hr_q;
  assign tk.o_minutes_bcd = mn_q;
  assign tk.o_seconds_bcd = sc_q;
  assign tk.o_pm          = P_24H ? 1'b0 : pm_q;
  assign tk.o_day_carry   = cy_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: 24 h and 12 h instances driven in lockstep against a seconds-of-day model
module tb_time_keeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int h = 0, m = 0, s = 0, st = 0;
  bit cy = 1'b0;
  logic [28:0] q24[$];
  logic [28:0] q12[$];
  time_keeper_if ia ();
  time_keeper_if ib ();
  time_keeper #(.P_24H(1'b1)) u24 (.i_clk(clk), .i_reset(rst), .tk(ia.slave));
  time_keeper #(.P_24H(1'b0)) u12 (.i_clk(clk), .i_reset(rst), .tk(ib.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction
  function automatic logic [28:0] exp24();
    return {bcd(h), bcd(m), bcd(s), 1'b0, st == 1, st == 2, cy};
  endfunction
  function automatic logic [28:0] exp12();
    int h12;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    return {bcd(h12), bcd(m), bcd(s), h >= 12, st == 1, st == 2, cy};
  endfunction
  function automatic logic [28:0] act(input logic [7:0] hh, mm, ss, input logic pm, sh, sm, dc);
    return {hh, mm, ss, pm, sh, sm, dc};
  endfunction
  task automatic model(input bit rs, tk, md, in);
    cy = 1'b0;
    if (rs) begin
      h = 0; m = 0; s = 0; st = 0;
    end else if (st == 0) begin
      if (tk) begin
        s++;
        if (s == 60) begin s = 0; m++; end
        if (m == 60) begin m = 0; h = (h + 1) % 24; end
        cy = (h == 0 && m == 0 && s == 0);
      end
      if (md) st = 1;
    end else if (st == 1) begin
      if (md) st = 2;
      else if (in) h = (h + 1) % 24;
    end else begin
      if (md) begin st = 0; s = 0; end
      else if (in) m = (m + 1) % 60;
    end
  endtask
  task automatic step(input string nm, input bit rs, tk, md, in);
    logic [28:0] e24, e12, a24, a12;
    rst = rs;
    ia.i_tick_1hz = tk; ia.i_btn_mode = md; ia.i_btn_inc = in;
    ib.i_tick_1hz = tk; ib.i_btn_mode = md; ib.i_btn_inc = in;
    model(rs, tk, md, in);
    q24.push_back(exp24());
    q12.push_back(exp12());
    @(posedge clk);
    #1;
    e24 = q24.pop_front();
    e12 = q12.pop_front();
    a24 = act(ia.o_hours_bcd, ia.o_minutes_bcd, ia.o_seconds_bcd, ia.o_pm, ia.o_set_hours, ia.o_set_minutes, ia.o_day_carry);
    a12 = act(ib.o_hours_bcd, ib.o_minutes_bcd, ib.o_seconds_bcd, ib.o_pm, ib.o_set_hours, ib.o_set_minutes, ib.o_day_carry);
    total += 2;
    if (a24 !== e24) begin
      bad++;
      $display("FAIL %s 24h got h=%h m=%h s=%h pm/sh/sm/cy=%b exp h=%h m=%h s=%h pm/sh/sm/cy=%b",
               nm, a24[28:21], a24[20:13], a24[12:5], a24[3:0], e24[28:21], e24[20:13], e24[12:5], e24[3:0]);
    end
    if (a12 !== e12) begin
      bad++;
      $display("FAIL %s 12h got h=%h m=%h s=%h pm/sh/sm/cy=%b exp h=%h m=%h s=%h pm/sh/sm/cy=%b",
               nm, a12[28:21], a12[20:13], a12[12:5], a12[4:0], e12[28:21], e12[20:13], e12[12:5], e12[4:0]);
    end
    rst = 1'b0;
    ia.i_tick_1hz = 1'b0; ia.i_btn_mode = 1'b0; ia.i_btn_inc = 1'b0;
    ib.i_tick_1hz = 1'b0; ib.i_btn_mode = 1'b0; ib.i_btn_inc = 1'b0;
  endtask
  task automatic goto(input int hh, mm, ss);
    step("goto_rst", 1, 0, 0, 0);
    step("goto_mode", 0, 0, 1, 0);
    repeat (hh) step("goto_hr", 0, 0, 0, 1);
    step("goto_mode", 0, 0, 1, 0);
    repeat (mm) step("goto_min", 0, 0, 0, 1);
    step("goto_mode", 0, 0, 1, 0);
    repeat (ss) step("goto_sec", 0, 1, 0, 0);
  endtask
  task automatic test_reset();
    step("reset", 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0);
    total++;
    if (ib.o_hours_bcd !== 8'h12 || ia.o_hours_bcd !== 8'h00) begin
      bad++;
      $display("FAIL reset_hours got 24h=%h 12h=%h exp 00/12", ia.o_hours_bcd, ib.o_hours_bcd);
    end
  endtask
  task automatic test_set();
    step("rst", 1, 0, 0, 0);
    repeat (37) step("tick", 0, 1, 0, 0);
    step("inc_in_run", 0, 0, 0, 1);
    step("mode_sh", 0, 0, 1, 0);
    step("tick_in_sh", 0, 1, 0, 0);
    repeat (3) step("inc_hr", 0, 0, 0, 1);
    step("mode_sm", 0, 0, 1, 0);
    step("tick_in_sm", 0, 1, 0, 0);
    for (int i = 0; i < 61; i++) step("inc_min", 0, i % 7 == 0, 0, 1);
    step("mode_run", 0, 0, 1, 0);
    total++;
    if ({ia.o_hours_bcd, ia.o_minutes_bcd, ia.o_seconds_bcd, ia.o_set_hours, ia.o_set_minutes} !== {8'h03, 8'h01, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL set_seq got %h:%h:%h exp 03:01:00", ia.o_hours_bcd, ia.o_minutes_bcd, ia.o_seconds_bcd);
    end
  endtask
  task automatic test_mode_inc_same();
    step("rst", 1, 0, 0, 0);
    step("mode_sh", 0, 0, 1, 0);
    step("inc_hr", 0, 0, 0, 1);
    step("mode_and_inc", 0, 0, 1, 1);
    step("inc_min", 0, 0, 0, 1);
    step("mode_run", 0, 0, 1, 0);
  endtask
  task automatic test_tick_mode();
    goto(9, 59, 59);
    step("tick_and_mode", 0, 1, 1, 0);
    total++;
    if ({ia.o_hours_bcd, ia.o_minutes_bcd, ia.o_seconds_bcd, ia.o_set_hours} !== {8'h10, 8'h00, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL tick_mode got %h:%h:%h sh=%b exp 10:00:00 sh=1", ia.o_hours_bcd, ia.o_minutes_bcd, ia.o_seconds_bcd, ia.o_set_hours);
    end
    step("mode_sm", 0, 0, 1, 0);
    step("mode_run", 0, 0, 1, 0);
  endtask
  task automatic test_rollover();
    goto(11, 59, 59);
    step("noon_tick", 0, 1, 0, 0);
    total++;
    if ({ib.o_hours_bcd, ib.o_pm, ib.o_day_carry} !== {8'h12, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL noon_12h got h=%h pm=%b cy=%b exp 12 1 0", ib.o_hours_bcd, ib.o_pm, ib.o_day_carry);
    end
    goto(23, 59, 59);
    step("midnight_tick", 0, 1, 0, 0);
    total++;
    if ({ia.o_hours_bcd, ia.o_day_carry, ib.o_hours_bcd, ib.o_pm, ib.o_day_carry} !== {8'h00, 1'b1, 8'h12, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL midnight got 24h=%h cy=%b 12h=%h pm=%b cy=%b exp 00 1 12 0 1",
               ia.o_hours_bcd, ia.o_day_carry, ib.o_hours_bcd, ib.o_pm, ib.o_day_carry);
    end
    step("after_midnight", 0, 0, 0, 0);
    step("tick_after", 0, 1, 0, 0);
  endtask
  task automatic test_reset_mid();
    goto(5, 7, 3);
    step("mode_sh", 0, 0, 1, 0);
    step("mode_sm", 0, 0, 1, 0);
    step("inc_min", 0, 0, 0, 1);
    step("rst_in_sm", 1, 1, 1, 1);
    step("idle_after_rst", 0, 0, 0, 0);
  endtask
  initial begin
    ia.i_tick_1hz = 1'b0; ia.i_btn_mode = 1'b0; ia.i_btn_inc = 1'b0;
    ib.i_tick_1hz = 1'b0; ib.i_btn_mode = 1'b0; ib.i_btn_inc = 1'b0;
    test_reset();
    test_set();
    test_mode_inc_same();
    test_tick_mode();
    test_rollover();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
